// File: rtl/cpu_io_wb_master.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_io_wb_master
//  Purpose  : Turns Z80-style I/O strobes into single classic Wishbone
//             cycles, stalling the CPU with WAIT and aborting on timeout.
//  Revision : 1.0  initial release
// ============================================================================
module cpu_io_wb_master #(
    parameter logic [15:0] TIMEOUT = 16'd255,
    parameter int          ADDR_W  = 3
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,

    input  logic              cpu_iorq_n,
    input  logic              cpu_rd_n,
    input  logic              cpu_wr_n,
    input  logic              cpu_sel,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_din,
    output logic [7:0]        cpu_dout,
    output logic              cpu_wait_n,

    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [ADDR_W-1:0] wb_adr_o,
    output logic [7:0]        wb_dat_o,
    input  logic [7:0]        wb_dat_i,
    input  logic              wb_ack_i,

    output logic              timeout_o,
    output logic              busy_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    localparam logic [15:0] c_last_cnt = TIMEOUT - 16'd1;

    logic [1:0]        r_state;
    logic [15:0]       r_cnt;
    logic              r_cyc;
    logic              r_we;
    logic [ADDR_W-1:0] r_adr;
    logic [7:0]        r_dat_o;
    logic [7:0]        r_dout;
    logic              r_timeout;

    logic w_req;
    logic w_expire;

    // Both strobes low together is treated as a bus glitch, not a request.
    assign w_req    = cpu_sel & ~cpu_iorq_n & (cpu_rd_n ^ cpu_wr_n);
    assign w_expire = (r_cnt == c_last_cnt);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            // Start in HOLD so a strobe active across reset is never issued.
            r_state   <= S_HOLD;
            r_cnt     <= 16'd0;
            r_cyc     <= 1'b0;
            r_we      <= 1'b0;
            r_adr     <= '0;
            r_dat_o   <= 8'h00;
            r_dout    <= 8'hFF;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_adr <= cpu_addr;
                        r_we  <= ~cpu_wr_n;
                        if (!cpu_wr_n) begin
                            r_dat_o <= cpu_din;
                        end
                        r_cyc   <= 1'b1;
                        r_cnt   <= 16'd0;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (wb_ack_i) begin
                        r_cyc <= 1'b0;
                        if (!r_we) begin
                            r_dout <= wb_dat_i;
                        end
                        r_state <= S_HOLD;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                        if (w_expire) begin
                            r_cyc     <= 1'b0;
                            r_timeout <= 1'b1;
                            if (!r_we) begin
                                r_dout <= 8'hFF;
                            end
                            r_state <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!w_req) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_cyc   <= 1'b0;
                    r_state <= S_HOLD;
                end
            endcase
        end
    end

    assign cpu_wait_n = ~(((r_state == S_IDLE) & w_req) | (r_state == S_REQ));
    assign busy_o     = (r_state == S_REQ);

    assign wb_cyc_o  = r_cyc;
    assign wb_stb_o  = r_cyc;
    assign wb_we_o   = r_we;
    assign wb_adr_o  = r_adr;
    assign wb_dat_o  = r_dat_o;
    assign cpu_dout  = r_dout;
    assign timeout_o = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_cpu_io_wb_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_io_wb_master
//  Purpose  : Self-checking bench for cpu_io_wb_master with a transaction
//             level reference model and a programmable-latency slave.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cpu_io_wb_master;

    localparam int c_timeout = 8;

    logic       wb_clk_i = 1'b0;
    logic       wb_rst_i = 1'b0;
    logic       cpu_iorq_n = 1'b1;
    logic       cpu_rd_n = 1'b1;
    logic       cpu_wr_n = 1'b1;
    logic       cpu_sel = 1'b0;
    logic [2:0] cpu_addr = 3'd0;
    logic [7:0] cpu_din = 8'h00;
    logic [7:0] cpu_dout;
    logic       cpu_wait_n;
    logic       wb_cyc_o, wb_stb_o, wb_we_o;
    logic [2:0] wb_adr_o;
    logic [7:0] wb_dat_o;
    logic [7:0] wb_dat_i;
    logic       wb_ack_i;
    logic       timeout_o, busy_o;

    int         checks = 0;
    int         failures = 0;

    // Slave: acks when stb has been high for ack_at cycles already
    int         ack_at = 255;
    logic [7:0] slave_dat = 8'h00;
    logic       stray_ack = 1'b0;
    int         stb_cnt = 0;

    assign wb_ack_i = (wb_stb_o && (stb_cnt == ack_at)) || stray_ack;
    assign wb_dat_i = slave_dat;

    // Bus monitor
    int         mon_stb = 0, mon_wait = 0, mon_busy = 0, mon_to = 0;
    int         mon_starts = 0, mon_unstable = 0;
    logic       mon_prev_stb = 1'b0;
    logic       cap_we = 1'b0;
    logic [2:0] cap_adr = 3'd0;
    logic [7:0] cap_dat = 8'h00;

    // Reference model state
    logic [7:0] m_dout = 8'hFF;
    logic [7:0] m_dat  = 8'h00;

    always #5 wb_clk_i = ~wb_clk_i;

    cpu_io_wb_master #(.TIMEOUT(16'd8), .ADDR_W(3)) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .cpu_iorq_n (cpu_iorq_n),
        .cpu_rd_n   (cpu_rd_n),
        .cpu_wr_n   (cpu_wr_n),
        .cpu_sel    (cpu_sel),
        .cpu_addr   (cpu_addr),
        .cpu_din    (cpu_din),
        .cpu_dout   (cpu_dout),
        .cpu_wait_n (cpu_wait_n),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_we_o    (wb_we_o),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_dat_i   (wb_dat_i),
        .wb_ack_i   (wb_ack_i),
        .timeout_o  (timeout_o),
        .busy_o     (busy_o)
    );

    always @(posedge wb_clk_i) begin
        stb_cnt <= wb_stb_o ? stb_cnt + 1 : 0;
        if (wb_stb_o) begin
            mon_stb <= mon_stb + 1;
            if (!mon_prev_stb) begin
                mon_starts <= mon_starts + 1;
                cap_we     <= wb_we_o;
                cap_adr    <= wb_adr_o;
                cap_dat    <= wb_dat_o;
            end else if (wb_we_o !== cap_we || wb_adr_o !== cap_adr || wb_dat_o !== cap_dat) begin
                mon_unstable <= mon_unstable + 1;
            end
        end
        if (wb_cyc_o !== wb_stb_o) mon_unstable <= mon_unstable + 1;
        if (!cpu_wait_n) mon_wait <= mon_wait + 1;
        if (busy_o)      mon_busy <= mon_busy + 1;
        if (timeout_o)   mon_to   <= mon_to + 1;
        mon_prev_stb <= wb_stb_o;
    end

    task automatic release_cpu();
        cpu_sel    = 1'b0;
        cpu_iorq_n = 1'b1;
        cpu_rd_n   = 1'b1;
        cpu_wr_n   = 1'b1;
    endtask

    // One CPU access: drive, hold until WAIT releases (+extra), release, check.
    task automatic do_access(input logic sel, input logic iorq_n, input logic rd_n,
                             input logic wr_n, input logic [2:0] adr, input logic [7:0] din,
                             input int ack, input logic [7:0] sdat, input int extra_hold,
                             input string name);
        int  s0, w0, b0, t0, st0, u0, n;
        bit  req, is_rd, to;
        int  exp_stb;
        @(negedge wb_clk_i);
        s0 = mon_stb; w0 = mon_wait; b0 = mon_busy; t0 = mon_to;
        st0 = mon_starts; u0 = mon_unstable;
        ack_at = ack; slave_dat = sdat;
        cpu_sel = sel; cpu_iorq_n = iorq_n; cpu_rd_n = rd_n; cpu_wr_n = wr_n;
        cpu_addr = adr; cpu_din = din;
        n = 0;
        do begin
            @(negedge wb_clk_i);
            n++;
        end while (!cpu_wait_n && n < 40);
        checks++;
        if (!cpu_wait_n) begin
            failures++;
            $display("FAIL %s wait_release: wait_n=%b after %0d cycles, required 1", name, cpu_wait_n, n);
        end
        repeat (extra_hold) @(negedge wb_clk_i);
        release_cpu();
        repeat (3) @(negedge wb_clk_i);

        req   = sel && !iorq_n && (rd_n ^ wr_n);
        is_rd = req && !rd_n;
        to    = req && (ack >= c_timeout);
        exp_stb = !req ? 0 : (to ? c_timeout : ack + 1);
        if (is_rd) m_dout = to ? 8'hFF : sdat;
        if (req && !wr_n) m_dat = din;

        checks++;
        if (mon_starts - st0 !== (req ? 1 : 0)) begin
            failures++;
            $display("FAIL %s cycles: got %0d required %0d", name, mon_starts - st0, req ? 1 : 0);
        end
        checks++;
        if (mon_stb - s0 !== exp_stb || mon_busy - b0 !== exp_stb) begin
            failures++;
            $display("FAIL %s stb_len: stb=%0d busy=%0d required %0d", name, mon_stb - s0, mon_busy - b0, exp_stb);
        end
        checks++;
        if (mon_wait - w0 !== (req ? exp_stb + 1 : 0)) begin
            failures++;
            $display("FAIL %s wait_len: got %0d required %0d", name, mon_wait - w0, req ? exp_stb + 1 : 0);
        end
        checks++;
        if (mon_to - t0 !== (to ? 1 : 0)) begin
            failures++;
            $display("FAIL %s timeout_pulses: got %0d required %0d", name, mon_to - t0, to ? 1 : 0);
        end
        checks++;
        if (cpu_dout !== m_dout) begin
            failures++;
            $display("FAIL %s cpu_dout: got %h required %h", name, cpu_dout, m_dout);
        end
        checks++;
        if (mon_unstable !== u0) begin
            failures++;
            $display("FAIL %s bus_stable: %0d unstable cycles, required 0", name, mon_unstable - u0);
        end
        if (req) begin
            checks++;
            if (cap_we !== !wr_n || cap_adr !== adr || cap_dat !== m_dat) begin
                failures++;
                $display("FAIL %s wb_fields: we=%b adr=%0d dat=%h required we=%b adr=%0d dat=%h",
                         name, cap_we, cap_adr, cap_dat, !wr_n, adr, m_dat);
            end
        end
    endtask

    task automatic check_reset_values(input string name);
        checks++;
        if (cpu_dout !== 8'hFF || wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || cpu_wait_n !== 1'b1 ||
            wb_we_o !== 1'b0 || wb_adr_o !== 3'd0 || wb_dat_o !== 8'h00 || timeout_o !== 1'b0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL %s: dout=%h cyc=%b stb=%b wait_n=%b we=%b adr=%0d dat=%h to=%b busy=%b required FF 0 0 1 0 0 00 0 0",
                     name, cpu_dout, wb_cyc_o, wb_stb_o, cpu_wait_n, wb_we_o, wb_adr_o, wb_dat_o, timeout_o, busy_o);
        end
    endtask

    task automatic test_reset();
        int st0;
        cpu_sel = 1'b1; cpu_iorq_n = 1'b0; cpu_rd_n = 1'b0; cpu_wr_n = 1'b1;
        #2 wb_rst_i = 1'b1;
        repeat (3) @(negedge wb_clk_i);
        check_reset_values("reset_state");
        st0 = mon_starts;
        wb_rst_i = 1'b0;
        repeat (5) @(negedge wb_clk_i);
        checks++;
        if (mon_starts !== st0 || cpu_wait_n !== 1'b1) begin
            failures++;
            $display("FAIL reset_held_strobe: cycles=%0d wait_n=%b required 0 1", mon_starts - st0, cpu_wait_n);
        end
        release_cpu();
        repeat (2) @(negedge wb_clk_i);
        m_dout = 8'hFF; m_dat = 8'h00;
    endtask

    task automatic test_write();
        do_access(1, 0, 1, 0, 3'd1, 8'h03, 1, 8'h00, 0, "write_fdc");
    endtask

    task automatic test_read();
        do_access(1, 0, 0, 1, 3'd0, 8'h00, 1, 8'h80, 20, "read_hold20");
        do_access(1, 0, 0, 1, 3'd5, 8'h00, 0, 8'h3C, 0, "read_zero_wait");
    endtask

    task automatic test_timeout();
        do_access(1, 0, 0, 1, 3'd2, 8'h00, 255, 8'h11, 0, "timeout_read");
        do_access(1, 0, 0, 1, 3'd3, 8'h00, c_timeout - 1, 8'h5A, 0, "ack_at_timeout");
        do_access(1, 0, 1, 0, 3'd4, 8'hA7, 255, 8'h00, 1, "timeout_write");
    endtask

    task automatic test_no_request();
        do_access(1, 0, 0, 0, 3'd6, 8'h99, 1, 8'h22, 0, "both_strobes_low");
        do_access(0, 0, 0, 1, 3'd6, 8'h00, 1, 8'h22, 0, "sel_low");
        do_access(1, 1, 0, 1, 3'd6, 8'h00, 1, 8'h22, 0, "iorq_high");
    endtask

    task automatic test_stray_ack();
        int st0;
        st0 = mon_starts;
        @(negedge wb_clk_i);
        slave_dat = 8'h42;
        stray_ack = 1'b1;
        repeat (3) @(negedge wb_clk_i);
        stray_ack = 1'b0;
        @(negedge wb_clk_i);
        checks++;
        if (cpu_dout !== m_dout || mon_starts !== st0 || timeout_o !== 1'b0) begin
            failures++;
            $display("FAIL stray_ack: dout=%h cycles=%0d required dout=%h cycles=0", cpu_dout, mon_starts - st0, m_dout);
        end
    endtask

    task automatic test_reset_in_req();
        do_access(1, 0, 1, 0, 3'd7, 8'hC3, 2, 8'h00, 0, "pre_reset_write");
        @(negedge wb_clk_i);
        ack_at = 255;
        cpu_sel = 1'b1; cpu_iorq_n = 1'b0; cpu_rd_n = 1'b0; cpu_wr_n = 1'b1; cpu_addr = 3'd2;
        repeat (3) @(negedge wb_clk_i);
        checks++;
        if (wb_stb_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_req_setup: stb=%b required 1", wb_stb_o);
        end
        #2 wb_rst_i = 1'b1;
        #1 check_reset_values("reset_in_req");
        @(negedge wb_clk_i);
        release_cpu();
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        repeat (2) @(negedge wb_clk_i);
        m_dout = 8'hFF; m_dat = 8'h00;
    endtask

    task automatic test_random();
        int acks[7] = '{0, 1, 2, 3, 6, 7, 255};
        int k;
        logic rd_n, wr_n;
        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 5);
            rd_n = !(k <= 1 || k == 4);
            wr_n = !((k >= 2 && k <= 3) || k == 4);
            do_access($urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0, rd_n, wr_n,
                      3'($urandom_range(0, 7)), 8'($urandom), acks[$urandom_range(0, 6)],
                      8'($urandom), $urandom_range(0, 3), "random");
        end
    endtask

    task automatic test_back_to_back();
        do_access(1, 0, 1, 0, 3'd1, 8'h5E, 1, 8'h00, 0, "b2b_write");
        do_access(1, 0, 0, 1, 3'd1, 8'h00, 0, 8'hE5, 0, "b2b_read");
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_no_request();
        test_stray_ack();
        test_back_to_back();
        test_reset_in_req();
        test_write();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
